// File: rtl/dxi_conv3x3_filter.sv
// 3x3 kernel filter with DXI valid/ready on both sides: capture stage (S1) and result stage (S2).
// Optional DXI_SAT_FLAG_EN adds o_sat_flag, registered with o_master_data, set when the clamp fired.
module dxi_conv3x3_filter #(
    parameter int PIX_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_dxi_valid,
    input  logic [9*PIX_W-1:0]   i_dxi_data,
    output logic                 o_dxi_ready,
    input  logic [1:0]           config_select,
    output logic                 o_dxi_out_valid,
    input  logic                 i_dxi_out_ready,
    output logic [PIX_W-1:0]     o_master_data
`ifdef DXI_SAT_FLAG_EN
    ,
    output logic                 o_sat_flag
`endif
);

    localparam int ACC_W = PIX_W + 6;
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << PIX_W) - 1);
    localparam logic signed [ACC_W-1:0] NINE  = ACC_W'(9);

    logic                   s1_valid_q, s1_valid_d;
    logic [9*PIX_W-1:0]     s1_data_q, s1_data_d;
    logic [1:0]             s1_sel_q, s1_sel_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [PIX_W-1:0]       s2_pix_q, s2_pix_d;

    logic                   s2_advance;
    logic                   accept;
    logic signed [ACC_W-1:0] px_e [9];
    logic signed [ACC_W-1:0] edges, corners, res;
    logic [PIX_W-1:0]       pix_clamped;
    logic                   clamp_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_px
            assign px_e[gi] = $signed({{(ACC_W-PIX_W){1'b0}}, s1_data_q[gi*PIX_W +: PIX_W]});
        end
    endgenerate

    assign edges   = px_e[1] + px_e[3] + px_e[5] + px_e[7];
    assign corners = px_e[0] + px_e[2] + px_e[6] + px_e[8];

    // Gaussian sum is never negative, so the arithmetic shift equals truncating division.
    always_comb begin
        res = '0;
        case (s1_sel_q)
            2'b00:   res = (px_e[4] <<< 2) - edges;
            2'b01:   res = (px_e[4] <<< 3) - (edges + corners);
            2'b10:   res = (corners + (edges <<< 1) + (px_e[4] <<< 2)) >>> 4;
            default: res = (corners + edges + px_e[4]) / NINE;
        endcase
    end

    always_comb begin
        pix_clamped = res[PIX_W-1:0];
        clamp_hit   = 1'b0;
        if (res[ACC_W-1]) begin
            pix_clamped = '0;
            clamp_hit   = 1'b1;
        end else if (res > MAX_V) begin
            pix_clamped = '1;
            clamp_hit   = 1'b1;
        end
    end

    assign s2_advance      = ~s2_valid_q | i_dxi_out_ready;
    assign o_dxi_ready     = ~s1_valid_q | s2_advance;
    assign accept          = i_dxi_valid & o_dxi_ready;
    assign o_dxi_out_valid = s2_valid_q;
    assign o_master_data   = s2_pix_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_sel_d   = s1_sel_q;
        s2_valid_d = s2_valid_q;
        s2_pix_d   = s2_pix_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = i_dxi_data;
            s1_sel_d   = config_select;
        end else if (s2_advance) begin
            s1_valid_d = 1'b0;
        end
        if (s2_advance) begin
            s2_valid_d = s1_valid_q;
            // Keep the last pixel on the bus when the stage drains empty.
            if (s1_valid_q) begin
                s2_pix_d = pix_clamped;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_sel_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_pix_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_sel_q   <= s1_sel_d;
            s2_valid_q <= s2_valid_d;
            s2_pix_q   <= s2_pix_d;
        end
    end

`ifdef DXI_SAT_FLAG_EN
    logic sat_q, sat_d;

    always_comb begin
        sat_d = sat_q;
        if (s2_advance && s1_valid_q) begin
            sat_d = clamp_hit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign o_sat_flag = sat_q;
`else
    logic unused_clamp;
    assign unused_clamp = clamp_hit;
`endif

endmodule

// File: tb/tb_dxi_conv3x3_filter.sv
// Directed bench for dxi_conv3x3_filter: single windows, streaming, backpressure, clamp, mid-stream reset.
module tb_dxi_conv3x3_filter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_dxi_valid;
    logic [71:0] i_dxi_data;
    logic        o_dxi_ready;
    logic [1:0]  config_select;
    logic        o_dxi_out_valid;
    logic        i_dxi_out_ready;
    logic [7:0]  o_master_data;
`ifdef DXI_SAT_FLAG_EN
    logic        o_sat_flag;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    dxi_conv3x3_filter #(.PIX_W(8)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_dxi_valid     (i_dxi_valid),
        .i_dxi_data      (i_dxi_data),
        .o_dxi_ready     (o_dxi_ready),
        .config_select   (config_select),
        .o_dxi_out_valid (o_dxi_out_valid),
        .i_dxi_out_ready (i_dxi_out_ready),
        .o_master_data   (o_master_data)
`ifdef DXI_SAT_FLAG_EN
        ,
        .o_sat_flag      (o_sat_flag)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [71:0] rep9(input logic [7:0] b);
        return {9{b}};
    endfunction

    // One window with valid dropped afterwards; result expected exactly one edge after the accept edge.
    task automatic send_one(input string tag, input logic [71:0] d, input logic [1:0] s,
                            input logic [7:0] exp, input logic sat_exp);
        i_dxi_out_ready = 1'b1;
        i_dxi_valid     = 1'b1;
        i_dxi_data      = d;
        config_select   = s;
        #1;
        check_eq({tag, "_rdy"}, 32'(o_dxi_ready), 32'd1);
        step();
        i_dxi_valid   = 1'b0;
        config_select = ~s;
        i_dxi_data    = ~d;
        check_eq({tag, "_early"}, 32'(o_dxi_out_valid), 32'd0);
        step();
        check_eq({tag, "_vld"}, 32'(o_dxi_out_valid), 32'd1);
        check_eq({tag, "_pix"}, 32'(o_master_data), 32'(exp));
`ifdef DXI_SAT_FLAG_EN
        check_eq({tag, "_sat"}, 32'(o_sat_flag), 32'(sat_exp));
`else
        if (sat_exp === 1'bx) $display("note: %s sat_exp unknown", tag);
`endif
        step();
        check_eq({tag, "_drain"}, 32'(o_dxi_out_valid), 32'd0);
        $display("txn %s data=%h sel=%0d -> %h", tag, d, s, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst           = 1'b1;
        i_dxi_valid     = 1'b0;
        i_dxi_data      = '0;
        config_select   = 2'b00;
        i_dxi_out_ready = 1'b1;
        repeat (3) step();
        i_rst = 1'b0;
        #1;
        check_eq("rst_vld", 32'(o_dxi_out_valid), 32'd0);
        check_eq("rst_pix", 32'(o_master_data), 32'd0);
        check_eq("rst_rdy", 32'(o_dxi_ready), 32'd1);
        step();

        send_one("gauss_5f", rep9(8'h5F), 2'b10, 8'h5F, 1'b0);
        send_one("lap8_neg", 72'hfff1f2f3f4f5f6f7f8, 2'b01, 8'h00, 1'b1);
        send_one("gauss_ff", rep9(8'hFF), 2'b10, 8'hFF, 1'b0);
        send_one("mean_a5", rep9(8'hA5), 2'b11, 8'hA5, 1'b0);
        send_one("lap4_5f", rep9(8'h5F), 2'b00, 8'h00, 1'b0);
        send_one("lap8_hi", 72'h00_00_00_00_FF_00_00_00_00, 2'b01, 8'hFF, 1'b1);
        send_one("lap4_mid", 72'h00_04_00_03_40_02_00_01_00, 2'b00, 8'hF6, 1'b0);
        send_one("lap4_lo", 72'hFF_FF_FF_FF_00_FF_FF_FF_FF, 2'b00, 8'h00, 1'b1);
        send_one("gauss_ctr", 72'h00_00_00_00_10_00_00_00_00, 2'b10, 8'h04, 1'b0);
        send_one("lap8_mid", 72'h00_00_00_00_20_00_00_00_10, 2'b01, 8'hF0, 1'b0);

        // Streaming: four back-to-back accepts, results on four consecutive cycles.
        i_dxi_out_ready = 1'b1;
        i_dxi_valid = 1'b1; i_dxi_data = rep9(8'hA5); config_select = 2'b11;
        #1; check_eq("st_rdy0", 32'(o_dxi_ready), 32'd1);
        step();
        i_dxi_data = rep9(8'hFF); config_select = 2'b10;
        #1; check_eq("st_rdy1", 32'(o_dxi_ready), 32'd1);
        check_eq("st_vld0", 32'(o_dxi_out_valid), 32'd0);
        step();
        i_dxi_data = 72'hfff1f2f3f4f5f6f7f8; config_select = 2'b11;
        check_eq("st_p0", 32'(o_master_data), 32'hA5);
        check_eq("st_v0", 32'(o_dxi_out_valid), 32'd1);
        step();
        i_dxi_data = rep9(8'h5F); config_select = 2'b10;
        check_eq("st_p1", 32'(o_master_data), 32'hFF);
        check_eq("st_v1", 32'(o_dxi_out_valid), 32'd1);
        step();
        i_dxi_valid = 1'b0;
        check_eq("st_p2", 32'(o_master_data), 32'hF5);
        check_eq("st_v2", 32'(o_dxi_out_valid), 32'd1);
        step();
        check_eq("st_p3", 32'(o_master_data), 32'h5F);
        check_eq("st_v3", 32'(o_dxi_out_valid), 32'd1);
        step();
        check_eq("st_end", 32'(o_dxi_out_valid), 32'd0);
        $display("txn stream A5 FF F5 5F");

        // Backpressure: S2 holds w0 for 5 stalled edges, exactly one extra window enters S1.
        i_dxi_valid = 1'b1; i_dxi_data = rep9(8'h11); config_select = 2'b11;
        step();
        i_dxi_valid = 1'b0;
        step();
        i_dxi_out_ready = 1'b0;
        i_dxi_valid = 1'b1; i_dxi_data = rep9(8'h22);
        #1;
        check_eq("bp_rdy_first", 32'(o_dxi_ready), 32'd1);
        check_eq("bp_hold0", 32'(o_master_data), 32'h11);
        step();
        i_dxi_data = rep9(8'h33);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("bp_rdy_%0d", i), 32'(o_dxi_ready), 32'd0);
            check_eq($sformatf("bp_vld_%0d", i), 32'(o_dxi_out_valid), 32'd1);
            check_eq($sformatf("bp_hold_%0d", i), 32'(o_master_data), 32'h11);
            step();
        end
        #1;
        check_eq("bp_hold_last", 32'(o_master_data), 32'h11);
        i_dxi_out_ready = 1'b1;
        #1;
        check_eq("bp_rdy_rel", 32'(o_dxi_ready), 32'd1);
        step();
        i_dxi_valid = 1'b0;
        check_eq("bp_o1", 32'(o_master_data), 32'h22);
        step();
        check_eq("bp_o2", 32'(o_master_data), 32'h33);
        check_eq("bp_v2", 32'(o_dxi_out_valid), 32'd1);
        step();
        check_eq("bp_end", 32'(o_dxi_out_valid), 32'd0);
        $display("txn backpressure 11 22 33");

        // Reset with both stages full, then normal operation resumes.
        i_dxi_out_ready = 1'b0;
        i_dxi_valid = 1'b1; i_dxi_data = rep9(8'h44); config_select = 2'b11;
        step();
        i_dxi_data = rep9(8'h55);
        step();
        i_dxi_valid = 1'b0;
        check_eq("rm_full", 32'(o_dxi_out_valid), 32'd1);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_dxi_out_ready = 1'b1;
        check_eq("rm_vld", 32'(o_dxi_out_valid), 32'd0);
        check_eq("rm_rdy", 32'(o_dxi_ready), 32'd1);
        step();
        check_eq("rm_stale1", 32'(o_dxi_out_valid), 32'd0);
        step();
        check_eq("rm_stale2", 32'(o_dxi_out_valid), 32'd0);
        send_one("post_rst", rep9(8'h66), 2'b11, 8'h66, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
